guess_entry: RTL
================

# guess_entry

Digit-entry front end for the Bulls-and-Cows game. Collects keypad presses into a three-digit, all-distinct number and supports backspace, clear and enter. On enter it presents the number on num1/num2/num3 with a one-cycle num_rdy pulse. It sits directly upstream of the game display/scoring stage and drives that stage's iNum1/iNum2/iNum3/iNumRdy. The first submission after reset is the secret answer; later submissions are counted guesses, with a lockout after MAX_GUESS.

## Interface
- MAX_GUESS, 10: number of guesses accepted after the answer; legal range 1..15.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- key_valid  in  1  one-cycle strobe: key_code is valid this cycle.
- key_code  in  4  0x0–0x9 digit; 0xA backspace; 0xB clear; 0xC enter; 0xD–0xF ignored.
- num1  out  4  first-entered digit of last submission; reset 0.
- num2  out  4  second digit of last submission; reset 0.
- num3  out  4  third digit of last submission; reset 0.
- num_rdy  out  1  one-cycle pulse: num1..num3 carry a new submission; reset 0.
- entry1  out  4  live entry buffer slot 1 for on-screen echo; reset 0.
- entry2  out  4  live entry buffer slot 2; reset 0.
- entry3  out  4  live entry buffer slot 3; reset 0.
- entry_cnt  out  2  digits currently held, 0..3; reset 0.
- err  out  1  one-cycle pulse: the key was rejected; reset 0.
- answer_set  out  1  high once the first submission is accepted; reset 0.
- guess_cnt  out  4  guesses submitted after the answer, 0..MAX_GUESS; reset 0.
- locked  out  1  high when guess_cnt==MAX_GUESS; reset 0.

## Operation
- Two states:
  - ENTRY: reset state.
  - LOCKED: entered on the cycle guess_cnt reaches MAX_GUESS. Only reset leaves it.
- Keys are acted on only when key_valid=1. Exactly one action per strobe.
- Digit key in ENTRY:
  - Accepted when entry_cnt<3 and the digit differs from every occupied slot.
  - Stored in slot entry_cnt+1; entry_cnt increments.
  - If entry_cnt==3 or the digit is a duplicate: err pulse, no state change.
  - Unoccupied slots are never compared.
- Backspace:
  - entry_cnt>0: clear the highest occupied slot to 0 and decrement entry_cnt.
  - entry_cnt==0: err pulse.
- Clear: all slots to 0, entry_cnt to 0; never raises err.
- Enter with entry_cnt==3:
  - num1..num3 <= entry1..entry3 and num_rdy pulses.
  - Entry buffer and entry_cnt are cleared.
  - If answer_set==0, answer_set goes to 1; otherwise guess_cnt increments.
- Enter with entry_cnt<3: err pulse, no other effect.
- LOCKED:
  - Every valid key, including 0xD–0xF, produces an err pulse and nothing else.
  - The entry buffer and num outputs hold.
- Codes 0xD–0xF in ENTRY: ignored, no err.
- num1..num3 hold their value between submissions.
- guess_cnt saturates at MAX_GUESS and never wraps.

## Timing
- All outputs are registered.
- A key sampled at rising edge N updates its outputs after edge N, visible during cycle N+1.
- num_rdy and err are high for exactly one cycle per triggering key, and never both in the same cycle.
- Back-to-back key_valid on consecutive cycles is legal. Each key sees the state left by the previous one.
- The transition to LOCKED and the final num_rdy occur on the same edge. A key in the very next cycle is already rejected.
- Reset asserted asynchronously at any time, including mid-entry or during the num_rdy cycle:
  - All outputs go to 0 immediately and num_rdy is suppressed.
  - After reset deasserts, the first clk edge with key_valid is processed normally.
- key_code is ignored when key_valid=0.

## Test plan
- Answer entry: keys 3,7,1,enter → entry_cnt steps 1,2,3,0. num1/2/3=3/7/1 with a single num_rdy pulse; answer_set=1, guess_cnt=0.
- Duplicate and overflow rejection:
  - Keys 5,5 → err on the second key, entry_cnt=1.
  - Then 2,9,4 → err on 4, entries=5/2/9.
  - Enter → num=5/2/9.
- Editing: keys 1,2,backspace,backspace,backspace → entry_cnt 2,1,0, then err. Then 8,clear,enter → entry_cnt 0 and err on enter, no num_rdy.
- Lockout with MAX_GUESS=2:
  - Submit 1,2,3 (answer), then 4,5,6 → guess_cnt=1.
  - Submit 7,8,9 → guess_cnt=2, locked=1 on the same edge as num_rdy.
  - Key 0 next cycle → err; num stays 7/8/9.
- Async reset mid-entry: after keys 6,4, pulse reset between clock edges → all outputs 0 immediately. Then 6,4,2,enter → num=6/4/2 and answer_set=1.
- Reset coincident with enter: assert reset in the same cycle as an enter with 3 digits → num_rdy never seen high, num stays 0, answer_set=0.

Source files
------------

// File: rtl/guess_entry.sv
// Keypad digit-entry front end for Bulls-and-Cows: builds a three-distinct-digit number,
// submits it as the answer first and as counted guesses afterwards, then locks out.
module guess_entry #(
    parameter int unsigned MAX_GUESS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic       num_rdy,
    output logic [3:0] entry1,
    output logic [3:0] entry2,
    output logic [3:0] entry3,
    output logic [1:0] entry_cnt,
    output logic       err,
    output logic       answer_set,
    output logic [3:0] guess_cnt,
    output logic       locked
);

    localparam logic [3:0] KeyBksp  = 4'hA;
    localparam logic [3:0] KeyClear = 4'hB;
    localparam logic [3:0] KeyEnter = 4'hC;
    localparam logic [3:0] GuessMax = 4'(MAX_GUESS);

    typedef enum logic [0:0] {StEntry, StLocked} state_e;

    state_e          state_q, state_d;
    logic [2:0][3:0] entry_q, entry_d;
    logic [2:0][3:0] num_q, num_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            num_rdy_q, num_rdy_d;
    logic            err_q, err_d;
    logic            answer_set_q, answer_set_d;
    logic [3:0]      guess_cnt_q, guess_cnt_d;

    // Key decode: exactly one action per strobe.
    logic is_digit, dup, full;
    logic do_store, do_bksp, do_clear, do_submit, reject;

    always_comb begin
        is_digit = (key_code <= 4'd9);
        full     = (cnt_q == 2'd3);
        dup      = 1'b0;
        // Only occupied slots take part in the duplicate check.
        for (int i = 0; i < 3; i++) begin
            if ((2'(i) < cnt_q) && (entry_q[i] == key_code)) begin
                dup = 1'b1;
            end
        end

        do_store  = 1'b0;
        do_bksp   = 1'b0;
        do_clear  = 1'b0;
        do_submit = 1'b0;
        reject    = 1'b0;

        if (key_valid) begin
            if (state_q == StLocked) begin
                reject = 1'b1;
            end else if (is_digit) begin
                if (full || dup) begin
                    reject = 1'b1;
                end else begin
                    do_store = 1'b1;
                end
            end else begin
                unique case (key_code)
                    KeyBksp: begin
                        if (cnt_q == 2'd0) reject = 1'b1;
                        else               do_bksp = 1'b1;
                    end
                    KeyClear: do_clear = 1'b1;
                    KeyEnter: begin
                        if (full) do_submit = 1'b1;
                        else      reject    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEntry;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. The final guess locks on the same edge that raises num_rdy.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEntry: begin
                if (do_submit && answer_set_q && (guess_cnt_q == GuessMax - 4'd1)) begin
                    state_d = StLocked;
                end
            end
            StLocked: state_d = StLocked;
            default:  state_d = StEntry;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        locked = (state_q == StLocked);
    end

    // Datapath next state.
    always_comb begin
        entry_d      = entry_q;
        cnt_d        = cnt_q;
        num_d        = num_q;
        num_rdy_d    = 1'b0;
        err_d        = reject;
        answer_set_d = answer_set_q;
        guess_cnt_d  = guess_cnt_q;

        if (do_store) begin
            for (int i = 0; i < 3; i++) begin
                if (2'(i) == cnt_q) entry_d[i] = key_code;
            end
            cnt_d = cnt_q + 2'd1;
        end

        if (do_bksp) begin
            for (int i = 0; i < 3; i++) begin
                if (2'(i) == cnt_q - 2'd1) entry_d[i] = 4'd0;
            end
            cnt_d = cnt_q - 2'd1;
        end

        if (do_clear) begin
            entry_d = '0;
            cnt_d   = 2'd0;
        end

        if (do_submit) begin
            num_d     = entry_q;
            num_rdy_d = 1'b1;
            entry_d   = '0;
            cnt_d     = 2'd0;
            if (!answer_set_q) begin
                answer_set_d = 1'b1;
            end else if (guess_cnt_q != GuessMax) begin
                guess_cnt_d = guess_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q      <= '0;
            cnt_q        <= 2'd0;
            num_q        <= '0;
            num_rdy_q    <= 1'b0;
            err_q        <= 1'b0;
            answer_set_q <= 1'b0;
            guess_cnt_q  <= 4'd0;
        end else begin
            entry_q      <= entry_d;
            cnt_q        <= cnt_d;
            num_q        <= num_d;
            num_rdy_q    <= num_rdy_d;
            err_q        <= err_d;
            answer_set_q <= answer_set_d;
            guess_cnt_q  <= guess_cnt_d;
        end
    end

    always_comb begin
        num1       = num_q[0];
        num2       = num_q[1];
        num3       = num_q[2];
        num_rdy    = num_rdy_q;
        entry1     = entry_q[0];
        entry2     = entry_q[1];
        entry3     = entry_q[2];
        entry_cnt  = cnt_q;
        err        = err_q;
        answer_set = answer_set_q;
        guess_cnt  = guess_cnt_q;
    end

endmodule
